// File: rtl/bullet_pkg.sv
// Shared bullet constants and state encoding for the controller, drawer and collision logic.
// Default tuning values live here; the controller exposes most of them as parameters.
package bullet_pkg;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ARMED    = 2'd1,
        S_FLYING   = 2'd2,
        S_COOLDOWN = 2'd3
    } state_t;

    localparam int BULLET_W        = 8;
    localparam int BULLET_H        = 10;
    localparam int DEF_START_Y     = 440;
    localparam int DEF_SPEED       = 6;
    localparam int DEF_FRAME_LINE  = 481;
    localparam int DEF_AMMO        = 3;
    localparam int COOLDOWN_FR     = 4;

    // 1016 + BULLET_W wraps to 0 in 10 bits, so the parked bullet never overlaps the drawer window.
    localparam logic [9:0] PARK_X = 10'd1016;
    localparam logic [9:0] PARK_Y = 10'h3C0;  // -64

    function automatic logic [9:0] launch_col(input logic [9:0] gx);
        if (gx < 10'(BULLET_W / 2))
            return 10'd0;
        else
            return gx - 10'(BULLET_W / 2);
    endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// One-clk frame tick on the rising edge of (hcount==0 && vcount==FRAME_LINE).
// Edge detection keeps it to one tick per frame even when the pixel clock is slower than clk.
module frame_tick_gen #(
    parameter int FRAME_LINE = 481
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] hcount,
    input  logic [9:0] vcount,
    output logic       ft
);

    logic at_line;
    logic at_line_q;

    assign at_line = (hcount == 10'd0) && (vcount == 10'(FRAME_LINE));
    assign ft      = at_line && !at_line_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            at_line_q <= 1'b0;
        else
            at_line_q <= at_line;
    end

endmodule

// File: rtl/bullet_controller.sv
// Bullet motion controller: fire/ammo handling, launch at gun column, per-frame climb, parking.
// Optional BULLET_COOLDOWN_EN adds a COOLDOWN state holding off fire for COOLDOWN_FR frames.
//
// state    | meaning
// IDLE     | bullet parked, waiting for fire with ammo left
// ARMED    | shot accepted, launch column latched, waiting for the frame tick
// FLYING   | bullet on screen, climbing SPEED rows per frame
// COOLDOWN | bullet parked after retire, counting frames before re-arming
module bullet_controller
    import bullet_pkg::*;
#(
    parameter int START_Y    = DEF_START_Y,
    parameter int SPEED      = DEF_SPEED,
    parameter int FRAME_LINE = DEF_FRAME_LINE,
    parameter int AMMO       = DEF_AMMO
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] hcount,
    input  logic [9:0] vcount,
    input  logic       fire,
    input  logic [9:0] gun_x,
    input  logic       hit,
    input  logic       reload,
    output logic [9:0] pos_x,
    output logic [9:0] pos_y,
    output logic       active,
    output logic       ready,
    output logic [3:0] ammo_left
);

    localparam logic signed [10:0] RETIRE_Y = 11'(-BULLET_H);

    logic              ft;
    state_t            state;
    state_t            nxt_state;
    logic [9:0]        launch_x;
    logic [9:0]        nxt_launch;
    logic [9:0]        nxt_x;
    logic [9:0]        nxt_y;
    logic [3:0]        nxt_ammo;
    logic              accept;
    logic              retire;
    logic signed [10:0] next_y;

`ifdef BULLET_COOLDOWN_EN
    logic [3:0] cool_cnt;
`endif

    frame_tick_gen #(.FRAME_LINE(FRAME_LINE)) u_frame_tick (
        .clk    (clk),
        .reset  (reset),
        .hcount (hcount),
        .vcount (vcount),
        .ft     (ft)
    );

    assign next_y = {pos_y[9], pos_y} - 11'(SPEED);
    assign accept = (state == S_IDLE) && fire && (ammo_left != 4'd0);

    always_comb begin
        nxt_state  = state;
        nxt_launch = launch_x;
        nxt_x      = pos_x;
        nxt_y      = pos_y;
        nxt_ammo   = ammo_left;
        retire     = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    nxt_state  = S_ARMED;
                    nxt_launch = launch_col(gun_x);
                    nxt_ammo   = ammo_left - 4'd1;
                end
            end
            S_ARMED: begin
                if (ft) begin
                    nxt_state = S_FLYING;
                    nxt_x     = launch_x;
                    nxt_y     = 10'(START_Y);
                end
            end
            S_FLYING: begin
                // hit wins over a coincident frame tick: the bullet parks without moving
                if (hit || (ft && (next_y <= RETIRE_Y)))
                    retire = 1'b1;
                else if (ft)
                    nxt_y = next_y[9:0];
            end
`ifdef BULLET_COOLDOWN_EN
            S_COOLDOWN: begin
                if (ft && (cool_cnt <= 4'd1))
                    nxt_state = S_IDLE;
            end
`endif
            default: nxt_state = S_IDLE;
        endcase
        if (retire) begin
            nxt_x = PARK_X;
            nxt_y = PARK_Y;
`ifdef BULLET_COOLDOWN_EN
            nxt_state = S_COOLDOWN;
`else
            nxt_state = S_IDLE;
`endif
        end
        if (reload)
            nxt_ammo = accept ? 4'(AMMO - 1) : 4'(AMMO);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            launch_x  <= 10'd0;
            pos_x     <= PARK_X;
            pos_y     <= PARK_Y;
            ammo_left <= 4'(AMMO);
            active    <= 1'b0;
            ready     <= 1'b1;
        end else begin
            state     <= nxt_state;
            launch_x  <= nxt_launch;
            pos_x     <= nxt_x;
            pos_y     <= nxt_y;
            ammo_left <= nxt_ammo;
            active    <= (nxt_state == S_FLYING);
            ready     <= (nxt_state == S_IDLE) && (nxt_ammo != 4'd0);
        end
    end

`ifdef BULLET_COOLDOWN_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cool_cnt <= 4'd0;
        else if (retire)
            cool_cnt <= 4'(COOLDOWN_FR);
        else if ((state == S_COOLDOWN) && ft && (cool_cnt != 4'd0))
            cool_cnt <= cool_cnt - 4'd1;
    end
`endif

endmodule

// File: tb/tb_bullet_controller.sv
// Directed bench for bullet_controller: vector table plus hand-written multi-frame sequences.
module tb_bullet_controller;

    logic       clk;
    logic       reset;
    logic [9:0] hcount;
    logic [9:0] vcount;
    logic       fire;
    logic [9:0] gun_x;
    logic       hit;
    logic       reload;
    logic [9:0] pos_x;
    logic [9:0] pos_y;
    logic       active;
    logic       ready;
    logic [3:0] ammo_left;

    int total = 0;
    int bad   = 0;

    localparam logic [9:0] PX = 10'd1016;
    localparam logic [9:0] PY = 10'h3C0;

    bullet_controller dut (
        .clk       (clk),
        .reset     (reset),
        .hcount    (hcount),
        .vcount    (vcount),
        .fire      (fire),
        .gun_x     (gun_x),
        .hit       (hit),
        .reload    (reload),
        .pos_x     (pos_x),
        .pos_y     (pos_y),
        .active    (active),
        .ready     (ready),
        .ammo_left (ammo_left)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       f;
        logic [9:0] gx;
        logic       h;
        logic       rl;
        logic       tk;
        logic [9:0] ex;
        logic [9:0] ey;
        logic       ea;
        logic       er;
        logic [3:0] eam;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // one stimulus cycle followed by a quiet cycle so consecutive frame ticks stay distinct
    task automatic cyc(input logic f, input logic [9:0] g, input logic h, input logic rl,
                       input logic tk);
        fire = f; gun_x = g; hit = h; reload = rl;
        if (tk) begin hcount = 10'd0; vcount = 10'd481; end
        step();
        fire = 1'b0; hit = 1'b0; reload = 1'b0; hcount = 10'd1; vcount = 10'd0;
        step();
    endtask

    task automatic tick();
        cyc(1'b0, gun_x, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic drain(input logic exp_rdy);
`ifdef BULLET_COOLDOWN_EN
        repeat (3) tick();
        chk("cooldown_ready_low", 32'(ready), 32'd0);
        tick();
`endif
        chk("ready_after_retire", 32'(ready), 32'(exp_rdy));
    endtask

    initial begin
        int launches;
        logic prev_a;

        vecs[0] = '{1'b1, 10'd200, 1'b0, 1'b0, 1'b0, PX,     PY,     1'b0, 1'b0, 4'd2};
        vecs[1] = '{1'b0, 10'd200, 1'b0, 1'b0, 1'b0, PX,     PY,     1'b0, 1'b0, 4'd2};
        vecs[2] = '{1'b0, 10'd200, 1'b0, 1'b0, 1'b1, 10'd196, 10'd440, 1'b1, 1'b0, 4'd2};
        vecs[3] = '{1'b0, 10'd200, 1'b0, 1'b0, 1'b1, 10'd196, 10'd434, 1'b1, 1'b0, 4'd2};
        vecs[4] = '{1'b0, 10'd200, 1'b0, 1'b0, 1'b1, 10'd196, 10'd428, 1'b1, 1'b0, 4'd2};
        vecs[5] = '{1'b0, 10'd200, 1'b0, 1'b0, 1'b1, 10'd196, 10'd422, 1'b1, 1'b0, 4'd2};
        vecs[6] = '{1'b1, 10'd10,  1'b0, 1'b0, 1'b0, 10'd196, 10'd422, 1'b1, 1'b0, 4'd2};
        vecs[7] = '{1'b0, 10'd10,  1'b0, 1'b1, 1'b0, 10'd196, 10'd422, 1'b1, 1'b0, 4'd3};

        reset = 1'b0; fire = 1'b0; gun_x = 10'd0; hit = 1'b0; reload = 1'b0;
        hcount = 10'd1; vcount = 10'd0;
        repeat (2) step();
        chk("rst_pos_x", 32'(pos_x), 32'(PX));
        chk("rst_pos_y", 32'(pos_y), 32'(PY));
        chk("rst_ammo", 32'(ammo_left), 32'd3);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_active", 32'(active), 32'd0);
        reset = 1'b1;
        step();

        for (int i = 0; i < 8; i++) begin
            cyc(vecs[i].f, vecs[i].gx, vecs[i].h, vecs[i].rl, vecs[i].tk);
            chk($sformatf("vec%0d_pos_x", i), 32'(pos_x), 32'(vecs[i].ex));
            chk($sformatf("vec%0d_pos_y", i), 32'(pos_y), 32'(vecs[i].ey));
            chk($sformatf("vec%0d_active", i), 32'(active), 32'(vecs[i].ea));
            chk($sformatf("vec%0d_ready", i), 32'(ready), 32'(vecs[i].er));
            chk($sformatf("vec%0d_ammo", i), 32'(ammo_left), 32'(vecs[i].eam));
        end

        // hit and frame tick together while flying: park without the decrement
        cyc(1'b0, 10'd0, 1'b1, 1'b0, 1'b1);
        chk("hit_ft_pos_y", 32'(pos_y), 32'(PY));
        chk("hit_ft_pos_x", 32'(pos_x), 32'(PX));
        chk("hit_ft_active", 32'(active), 32'd0);
        drain(1'b1);
        chk("hit_ft_ammo", 32'(ammo_left), 32'd3);

        // hit while armed is ignored
        cyc(1'b1, 10'd100, 1'b0, 1'b0, 1'b0);
        chk("armed_ammo", 32'(ammo_left), 32'd2);
        cyc(1'b0, 10'd100, 1'b1, 1'b0, 1'b0);
        chk("armed_hit_active", 32'(active), 32'd0);
        cyc(1'b0, 10'd100, 1'b1, 1'b0, 1'b1);
        chk("armed_hit_launch_x", 32'(pos_x), 32'd96);
        chk("armed_hit_launch_y", 32'(pos_y), 32'd440);
        chk("armed_hit_active2", 32'(active), 32'd1);

        // fly off the top: ft #75 after launch retires at -10
        repeat (74) tick();
        chk("top_pos_y_74", 32'(pos_y), 32'h3FC);
        chk("top_active_74", 32'(active), 32'd1);
        tick();
        chk("top_pos_y_75", 32'(pos_y), 32'(PY));
        chk("top_pos_x_75", 32'(pos_x), 32'(PX));
        chk("top_active_75", 32'(active), 32'd0);
        drain(1'b1);

        // gun_x below half width clamps to column 0
        cyc(1'b1, 10'd2, 1'b0, 1'b0, 1'b0);
        chk("clamp_ammo", 32'(ammo_left), 32'd1);
        tick();
        chk("clamp_pos_x", 32'(pos_x), 32'd0);
        chk("clamp_pos_y", 32'(pos_y), 32'd440);
        cyc(1'b0, 10'd0, 1'b1, 1'b0, 1'b0);
        chk("clamp_hit_pos_y", 32'(pos_y), 32'(PY));
        drain(1'b1);

        // last shot, then empty magazine
        cyc(1'b1, 10'd300, 1'b0, 1'b0, 1'b0);
        chk("last_ammo", 32'(ammo_left), 32'd0);
        chk("last_ready", 32'(ready), 32'd0);
        tick();
        cyc(1'b0, 10'd0, 1'b1, 1'b0, 1'b0);
        drain(1'b0);
        cyc(1'b1, 10'd300, 1'b0, 1'b0, 1'b0);
        chk("empty_ammo", 32'(ammo_left), 32'd0);
        chk("empty_ready", 32'(ready), 32'd0);
        tick();
        chk("empty_no_launch_y", 32'(pos_y), 32'(PY));
        chk("empty_no_launch_a", 32'(active), 32'd0);
        cyc(1'b0, 10'd0, 1'b0, 1'b1, 1'b0);
        chk("reload_ammo", 32'(ammo_left), 32'd3);
        chk("reload_ready", 32'(ready), 32'd1);
        cyc(1'b1, 10'd50, 1'b0, 1'b1, 1'b0);
        chk("reload_fire_ammo", 32'(ammo_left), 32'd2);
        chk("reload_fire_ready", 32'(ready), 32'd0);
        tick();
        chk("reload_fire_pos_x", 32'(pos_x), 32'd46);
        chk("reload_fire_active", 32'(active), 32'd1);

        // asynchronous reset mid-flight takes effect without a clock edge
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_pos_x", 32'(pos_x), 32'(PX));
        chk("midrst_pos_y", 32'(pos_y), 32'(PY));
        chk("midrst_ammo", 32'(ammo_left), 32'd3);
        chk("midrst_ready", 32'(ready), 32'd1);
        chk("midrst_active", 32'(active), 32'd0);
        step();
        reset = 1'b1;
        step();

        // fire held for 200 frames with hits cutting every flight short
        launches = 0;
        prev_a = active;
        fire = 1'b1; gun_x = 10'd320;
        for (int f = 0; f < 200; f++) begin
            hcount = 10'd0; vcount = 10'd481;
            step();
            if (active && !prev_a) launches++;
            prev_a = active;
            hcount = 10'd1; vcount = 10'd0;
            step();
            if (active) hit = 1'b1;
            step();
            hit = 1'b0;
            if (active && !prev_a) launches++;
            prev_a = active;
            step();
        end
        fire = 1'b0;
        chk("held_fire_launches", 32'(launches), 32'd3);
        chk("held_fire_ammo", 32'(ammo_left), 32'd0);
        chk("held_fire_ready", 32'(ready), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
